// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch : PC / fetch stage for the Divvy core (start, halt, stall, redirect)
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module instr_fetch #(
  parameter int IW = 16,
  parameter int DW = 9,
  parameter int OW = 8,
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [IW-1:0] StartAddr,
  input  logic          Stall,
  input  logic          Halt,
  input  logic          JumpEn,
  input  logic [IW-1:0] JumpTarget,
  input  logic          BranchEn,
  input  logic [OW-1:0] BranchOff,
  output logic [IW-1:0] InstAddress,
  input  logic [DW-1:0] InstIn,
  output logic [DW-1:0] InstOut,
  output logic [IW-1:0] InstPC,
  output logic          InstValid,
  output logic          Done,
  output logic [CW-1:0] CycleCount
);

  localparam logic [1:0]    S_IDLE   = 2'd0;
  localparam logic [1:0]    S_RUN    = 2'd1;
  localparam logic [1:0]    S_HALTED = 2'd2;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] pc_q, pc_d;
  logic [DW-1:0] inst_q, inst_d;
  logic [IW-1:0] inst_pc_q, inst_pc_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          in_run;
  logic          take_halt;
  logic          take_jump;
  logic          take_branch;
  logic [IW-1:0] branch_off_ext;
  logic [IW-1:0] branch_target;

  // Redirects and halt only act on a live instruction; priority is halt > jump > branch.
  assign take_halt      = Halt && valid_q;
  assign take_jump      = JumpEn && valid_q && !take_halt;
  assign take_branch    = BranchEn && valid_q && !take_halt && !JumpEn;
  assign branch_off_ext = {{(IW-OW){BranchOff[OW-1]}}, BranchOff};
  assign branch_target  = inst_pc_q + branch_off_ext;

  // State register
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_RUN;
      end
      S_RUN: begin
        if (Start)          state_d = S_RUN;
        else if (take_halt) state_d = S_HALTED;
      end
      S_HALTED: begin
        if (Start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State-derived outputs
  always_comb begin
    in_run = (state_q == S_RUN);
    Done   = (state_q == S_HALTED);
  end

  // Datapath next values
  always_comb begin
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;

    if (Start) begin
      pc_d    = StartAddr;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (in_run) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);

      if (take_halt) begin
        valid_d = 1'b0;
      end else if (take_jump) begin
        pc_d    = JumpTarget;
        valid_d = 1'b0;
      end else if (take_branch) begin
        pc_d    = branch_target;
        valid_d = 1'b0;
      end else if (!Stall) begin
        inst_d    = InstIn;
        inst_pc_d = pc_q;
        valid_d   = 1'b1;
        pc_d      = pc_q + IW'(1);
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q      <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign InstAddress = pc_q;
  assign InstOut     = inst_q;
  assign InstPC      = inst_pc_q;
  assign InstValid   = valid_q;
  assign CycleCount  = cnt_q;

endmodule

`default_nettype wire
